// File: rtl/cg_rv_decode_stage.sv
`default_nettype none
// ============================================================================
// cg_rv_decode_stage : registered RV32/RV64 decode with RAW/WAW register scoreboard.
// Option macro CG_RV_DECODE_STALL_CNT_EN adds the saturating o_stall_cnt port.
// Revision: 1.0
// ============================================================================
module cg_rv_decode_stage #(
  parameter int XLEN       = 32,
  parameter int PERF_CNT_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [6:0]      o_opcode,
  output logic [4:0]      o_rd,
  output logic [2:0]      o_funct3,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [6:0]      o_funct7,
  output logic [XLEN-1:0] o_imm,
  output logic            o_we_rd,
  output logic            o_illegal,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd,
  input  logic            i_flush
`ifdef CG_RV_DECODE_STALL_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] o_stall_cnt
`endif
);

  localparam logic [6:0] c_OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] c_OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] c_OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] c_OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] c_OPC_STORE     = 7'b0100011;
  localparam logic [6:0] c_OPC_OP        = 7'b0110011;
  localparam logic [6:0] c_OPC_LUI       = 7'b0110111;
  localparam logic [6:0] c_OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] c_OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] c_OPC_JALR      = 7'b1100111;
  localparam logic [6:0] c_OPC_JAL       = 7'b1101111;
  localparam logic [6:0] c_OPC_SYSTEM    = 7'b1110011;
  localparam logic       c_IS_RV64       = (XLEN == 64);

  logic [31:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_use_rs1, w_use_rs2, w_writes, w_legal;
  logic            w_we_rd, w_hazard, w_ready, w_accept;
  logic [31:0]     w_set, w_clr;

  logic [31:0]     r_busy;
  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc, r_imm;
  logic            r_we_rd, r_illegal;

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  // All formats are already sign-extended to 32 bits; widen further for RV64.
  generate
    if (XLEN > 32) begin : g_imm_wide
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_narrow
      assign w_imm = w_imm32[XLEN-1:0];
    end
  endgenerate

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_writes  = 1'b0;
    w_legal   = 1'b0;
    w_imm32   = 32'd0;
    case (i_instr[6:0])
      c_OPC_LOAD:      begin w_legal = 1'b1; w_use_rs1 = 1'b1; w_writes = 1'b1; w_imm32 = w_imm_i; end
      c_OPC_OP_IMM:    begin w_legal = 1'b1; w_use_rs1 = 1'b1; w_writes = 1'b1; w_imm32 = w_imm_i; end
      c_OPC_JALR:      begin w_legal = 1'b1; w_use_rs1 = 1'b1; w_writes = 1'b1; w_imm32 = w_imm_i; end
      c_OPC_OP_IMM_32: begin w_legal = c_IS_RV64; w_use_rs1 = 1'b1; w_writes = 1'b1; w_imm32 = w_imm_i; end
      c_OPC_STORE:     begin w_legal = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm32 = w_imm_s; end
      c_OPC_BRANCH:    begin w_legal = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm32 = w_imm_b; end
      c_OPC_OP:        begin w_legal = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_writes = 1'b1; end
      c_OPC_OP_32:     begin w_legal = c_IS_RV64; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_writes = 1'b1; end
      c_OPC_LUI:       begin w_legal = 1'b1; w_writes = 1'b1; w_imm32 = w_imm_u; end
      c_OPC_AUIPC:     begin w_legal = 1'b1; w_writes = 1'b1; w_imm32 = w_imm_u; end
      c_OPC_JAL:       begin w_legal = 1'b1; w_writes = 1'b1; w_imm32 = w_imm_j; end
      c_OPC_MISC_MEM:  w_legal = 1'b1;
      c_OPC_SYSTEM:    w_legal = 1'b1;
      default:         w_legal = 1'b0;
    endcase
  end

  assign w_we_rd  = w_legal && w_writes && (i_instr[11:7] != 5'd0);
  // Busy state is registered only, so a writeback releases the stall one cycle later.
  assign w_hazard = (w_use_rs1 && (i_instr[19:15] != 5'd0) && r_busy[i_instr[19:15]]) ||
                    (w_use_rs2 && (i_instr[24:20] != 5'd0) && r_busy[i_instr[24:20]]) ||
                    (w_we_rd && r_busy[i_instr[11:7]]);
  assign w_ready  = (!r_valid || i_ready) && !w_hazard && !i_flush;
  assign w_accept = i_valid && w_ready;

  assign w_set = (w_accept && w_we_rd) ? (32'd1 << i_instr[11:7]) : 32'd0;
  assign w_clr = (i_wb_valid && (i_wb_rd != 5'd0)) ? (32'd1 << i_wb_rd) : 32'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 32'd0;
    end else if (i_flush) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_instr   <= 32'd0;
      r_pc      <= '0;
      r_imm     <= '0;
      r_we_rd   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_instr   <= i_instr;
      r_pc      <= i_pc;
      r_imm     <= w_imm;
      r_we_rd   <= w_we_rd;
      r_illegal <= !w_legal;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_ready   = w_ready;
  assign o_valid   = r_valid;
  assign o_pc      = r_pc;
  assign o_opcode  = r_instr[6:0];
  assign o_rd      = r_instr[11:7];
  assign o_funct3  = r_instr[14:12];
  assign o_rs1     = r_instr[19:15];
  assign o_rs2     = r_instr[24:20];
  assign o_funct7  = r_instr[31:25];
  assign o_imm     = r_imm;
  assign o_we_rd   = r_we_rd;
  assign o_illegal = r_illegal;

`ifdef CG_RV_DECODE_STALL_CNT_EN
  logic [PERF_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_valid && w_hazard && !i_flush && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + PERF_CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  logic w_unused_perf_cnt_w;
  assign w_unused_perf_cnt_w = (PERF_CNT_W > 0);
`endif

endmodule
`default_nettype wire
